// File: rtl/mole_game_ctrl_pkg.sv
// Shared definitions for the whack-a-mole controller: FSM encoding and the
// position LFSR (x^8+x^6+x^5+x^4+1, Fibonacci form).
package mole_game_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SPAWN    = 3'd1,
      ST_SHOW     = 3'd2,
      ST_FEEDBACK = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_step(input logic [7:0] lfsr);
      return {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
   endfunction

   // Map the LFSR onto cells 1..9, nudging forward so a cell never repeats.
   function automatic logic [3:0] pick_pos(input logic [7:0] lfsr, input logic [3:0] prev);
      logic [3:0] cand;
      cand = 4'(lfsr % 8'd9) + 4'd1;
      if (cand == prev) begin
         cand = (cand == 4'd9) ? 4'd1 : cand + 4'd1;
      end
      return cand;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: down-counter that pulses tick for one cycle on terminal
// count; clear reloads it so the next tick lands TICK_DIV cycles later.
module tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LOAD = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == '0);
      cnt_d = cnt_q - CW'(1);
      if (clear || tick) begin
         cnt_d = LOAD;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: lights a pseudo-random cell, waits for the
// matching key or a timeout, shows the result, and repeats for ROUNDS rounds.
//
// state    | meaning
// IDLE     | waiting for the first start edge
// SPAWN    | one cycle: pick and load the next cell
// SHOW     | cell lit, waiting for a hit or SHOW_TICKS timeout
// FEEDBACK | result held for FEEDBACK_TICKS
// DONE     | game over, score held until the next start edge
module mole_game_ctrl #(
   parameter int TICK_DIV       = 50000,
   parameter int SHOW_TICKS     = 800,
   parameter int FEEDBACK_TICKS = 200,
   parameter int ROUNDS         = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       inGame,
   output logic [3:0] position,
   output logic       hit,
   output logic [7:0] score,
   output logic       game_over
);

   import mole_game_ctrl_pkg::*;

   localparam logic [15:0] SHOW_LOAD = 16'(SHOW_TICKS - 1);
   localparam logic [15:0] FB_LOAD   = 16'(FEEDBACK_TICKS - 1);
   localparam logic [7:0]  ROUND_END = 8'(ROUNDS);

   state_e      state_q, state_d;
   logic [3:0]  position_q, position_d;
   logic [3:0]  prev_q, prev_d;
   logic        hit_q, hit_d;
   logic [7:0]  score_q, score_d;
   logic        game_over_q, game_over_d;
   logic        in_game_q, in_game_d;
   logic [7:0]  round_q, round_d;
   logic [15:0] ticks_q, ticks_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic        start_q, start_d;
   logic        start_rise, tick, tick_clear;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .tick  (tick)
   );

   assign start_rise = start & ~start_q;

   always_comb begin
      state_d     = state_q;
      position_d  = position_q;
      prev_d      = prev_q;
      hit_d       = hit_q;
      score_d     = score_q;
      game_over_d = game_over_q;
      round_d     = round_q;
      ticks_d     = ticks_q;
      lfsr_d      = lfsr_step(lfsr_q);
      start_d     = start;
      tick_clear  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_rise) begin
               state_d     = ST_SPAWN;
               score_d     = 8'd0;
               round_d     = 8'd0;
               game_over_d = 1'b0;
            end
         end
         ST_SPAWN: begin
            position_d = pick_pos(lfsr_q, prev_q);
            prev_d     = position_d;
            hit_d      = 1'b0;
            ticks_d    = SHOW_LOAD;
            tick_clear = 1'b1;
            state_d    = ST_SHOW;
         end
         ST_SHOW: begin
            // A hit wins over a timeout landing in the same cycle.
            if (key_valid && (key_code == position_q)) begin
               hit_d      = 1'b1;
               score_d    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
               ticks_d    = FB_LOAD;
               tick_clear = 1'b1;
               state_d    = ST_FEEDBACK;
            end else if (tick) begin
               if (ticks_q == 16'd0) begin
                  position_d = 4'd0;
                  hit_d      = 1'b0;
                  ticks_d    = FB_LOAD;
                  tick_clear = 1'b1;
                  state_d    = ST_FEEDBACK;
               end else begin
                  ticks_d = ticks_q - 16'd1;
               end
            end
         end
         ST_FEEDBACK: begin
            if (tick) begin
               if (ticks_q == 16'd0) begin
                  round_d = round_q + 8'd1;
                  if (round_d == ROUND_END) begin
                     position_d  = 4'd0;
                     hit_d       = 1'b0;
                     game_over_d = 1'b1;
                     state_d     = ST_DONE;
                  end else begin
                     state_d = ST_SPAWN;
                  end
               end else begin
                  ticks_d = ticks_q - 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_game_d = (state_d == ST_SPAWN) || (state_d == ST_SHOW) || (state_d == ST_FEEDBACK);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         position_q  <= 4'd0;
         prev_q      <= 4'd0;
         hit_q       <= 1'b0;
         score_q     <= 8'd0;
         game_over_q <= 1'b0;
         in_game_q   <= 1'b0;
         round_q     <= 8'd0;
         ticks_q     <= 16'd0;
         lfsr_q      <= LFSR_SEED;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         position_q  <= position_d;
         prev_q      <= prev_d;
         hit_q       <= hit_d;
         score_q     <= score_d;
         game_over_q <= game_over_d;
         in_game_q   <= in_game_d;
         round_q     <= round_d;
         ticks_q     <= ticks_d;
         lfsr_q      <= lfsr_d;
         start_q     <= start_d;
      end
   end

   assign inGame    = in_game_q;
   assign position  = position_q;
   assign hit       = hit_q;
   assign score     = score_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: cycle-level game model compared every cycle, plus
// directed scenarios with hand-derived timing expectations.
module tb_mole_game_ctrl;

   localparam int TICK_DIV = 4;
   localparam int SHOW_TICKS = 5;
   localparam int FEEDBACK_TICKS = 2;
   localparam int ROUNDS = 3;
   localparam int SHOW_LEN = SHOW_TICKS * TICK_DIV;
   localparam int FB_LEN = FEEDBACK_TICKS * TICK_DIV;

   localparam int P_IDLE = 0, P_SPAWN = 1, P_SHOW = 2, P_FB = 3, P_DONE = 4;

   logic       clk, rst, start, key_valid;
   logic [3:0] key_code, position;
   logic       inGame, hit, game_over;
   logic [7:0] score;

   int n_checks = 0;
   int n_fail = 0;
   int spawn_cnt = 0;

   mole_game_ctrl #(
      .TICK_DIV(TICK_DIV), .SHOW_TICKS(SHOW_TICKS),
      .FEEDBACK_TICKS(FEEDBACK_TICKS), .ROUNDS(ROUNDS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_code(key_code),
      .inGame(inGame), .position(position), .hit(hit), .score(score), .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] m_step(input logic [7:0] l);
      logic fb;
      fb = l[7] ^ l[5] ^ l[4] ^ l[3];
      return {l[6:0], fb};
   endfunction

   function automatic logic [3:0] m_cand(input logic [7:0] l, input logic [3:0] prev);
      int c;
      c = (int'(l) % 9) + 1;
      if (c == int'(prev)) c = (c == 9) ? 1 : c + 1;
      return 4'(c);
   endfunction

   // Game model: phase plus cycles remaining in the phase.
   int         m_phase, m_left, m_round;
   logic [3:0] m_pos, m_prev;
   logic [7:0] m_score, m_lfsr;
   logic       m_hit, m_over, m_start;

   always @(posedge clk or negedge rst) begin : p_model
      int ph, left, rnd;
      logic [3:0] pos, prv;
      logic [7:0] sc;
      logic ht, ov, st_rise;
      if (!rst) begin
         m_phase <= P_IDLE; m_left <= 0; m_round <= 0;
         m_pos <= 4'd0; m_prev <= 4'd0; m_score <= 8'd0;
         m_hit <= 1'b0; m_over <= 1'b0; m_start <= 1'b0; m_lfsr <= 8'hA5;
      end else begin
         ph = m_phase; left = m_left; rnd = m_round;
         pos = m_pos; prv = m_prev; sc = m_score; ht = m_hit; ov = m_over;
         st_rise = start && !m_start;
         case (ph)
            P_IDLE, P_DONE: if (st_rise) begin
               ph = P_SPAWN; sc = 8'd0; rnd = 0; ov = 1'b0;
            end
            P_SPAWN: begin
               pos = m_cand(m_lfsr, prv); prv = pos; ht = 1'b0;
               ph = P_SHOW; left = SHOW_LEN;
            end
            P_SHOW: begin
               if (key_valid && key_code == pos) begin
                  ht = 1'b1; sc = (sc == 8'd255) ? sc : sc + 8'd1;
                  ph = P_FB; left = FB_LEN;
               end else if (left == 1) begin
                  pos = 4'd0; ht = 1'b0; ph = P_FB; left = FB_LEN;
               end else left = left - 1;
            end
            P_FB: begin
               if (left == 1) begin
                  rnd = rnd + 1;
                  if (rnd == ROUNDS) begin
                     ph = P_DONE; ov = 1'b1; pos = 4'd0; ht = 1'b0;
                  end else ph = P_SPAWN;
               end else left = left - 1;
            end
            default: ph = P_IDLE;
         endcase
         m_phase <= ph; m_left <= left; m_round <= rnd;
         m_pos <= pos; m_prev <= prv; m_score <= sc; m_hit <= ht; m_over <= ov;
         m_start <= start; m_lfsr <= m_step(m_lfsr);
      end
   end

   logic [3:0] last_spawn = 4'd0;

   always @(negedge clk) begin
      logic m_ingame;
      m_ingame = (m_phase == P_SPAWN) || (m_phase == P_SHOW) || (m_phase == P_FB);
      n_checks++;
      if (inGame !== m_ingame || position !== m_pos || hit !== m_hit ||
          score !== m_score || game_over !== m_over) begin
         n_fail++;
         $display("FAIL model_cycle t=%0t got ingame=%b pos=%0d hit=%b score=%0d over=%b, want ingame=%b pos=%0d hit=%b score=%0d over=%b",
                  $time, inGame, position, hit, score, game_over, m_ingame, m_pos, m_hit, m_score, m_over);
      end
      if (!rst) last_spawn = 4'd0;
      else if (m_phase == P_SHOW && m_left == SHOW_LEN) begin
         n_checks++;
         if (position == last_spawn || position == 4'd0 || position > 4'd9) begin
            n_fail++;
            $display("FAIL spawn_repeat t=%0t got pos=%0d previous=%0d", $time, position, last_spawn);
         end
         last_spawn = position;
         spawn_cnt++;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_show0();
      int n = 0;
      while (!(m_phase == P_SHOW && m_left == SHOW_LEN) && n < 200) begin
         cyc(1);
         n++;
      end
      if (n >= 200) chk("wait_show_timeout", n, 0);
   endtask

   task automatic wait_over();
      int n = 0;
      while (!game_over && n < 60) begin
         cyc(1);
         n++;
      end
      if (n >= 60) chk("wait_over_timeout", n, 0);
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      cyc(1);
      key_valid = 1'b0;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog t=%0t run did not complete", $time);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, g;
      rst = 1'b0; start = 1'b0; key_valid = 1'b0; key_code = 4'd0;

      chk("pin_lfsr_step", int'(m_step(8'hA5)), 'h4A);
      chk("pin_lfsr_step2", int'(m_step(m_step(8'hA5))), 'h95);
      chk("pin_cand", int'(m_cand(8'hA5, 4'd0)), 4);
      chk("pin_cand_repeat", int'(m_cand(8'hA5, 4'd4)), 5);
      chk("pin_cand_wrap", int'(m_cand(8'd8, 4'd9)), 1);

      cyc(3);
      chk("rst_ingame", int'(inGame), 0);
      chk("rst_position", int'(position), 0);
      chk("rst_hit", int'(hit), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_game_over", int'(game_over), 0);

      rst = 1'b1;
      press(4'd4);
      cyc(8);

      // Start edge in cycle C
      start = 1'b1;
      chk("idle_ingame", int'(inGame), 0);
      cyc(1);
      chk("spawn_ingame", int'(inGame), 1);
      start = 1'b0;
      cyc(1);
      chk("show_pos_range", int'(position >= 4'd1 && position <= 4'd9), 1);
      chk("show_score0", int'(score), 0);

      // Round 1: hit three cycles into SHOW
      cyc(3);
      press(m_pos);
      chk("hit_set", int'(hit), 1);
      chk("hit_score", int'(score), 1);
      n = 0;
      while (hit && n < 50) begin
         key_valid = (n == 2);
         key_code  = m_pos;
         n++;
         cyc(1);
      end
      key_valid = 1'b0;
      chk("hit_hold_cycles", n, FB_LEN + 1);
      chk("round2_pos_range", int'(position >= 4'd1 && position <= 4'd9), 1);

      // Round 2: no key, stray start edge mid-SHOW
      n = 0;
      while (position != 4'd0 && n < 100) begin
         start = (n == 5);
         n++;
         cyc(1);
      end
      start = 1'b0;
      chk("show_timeout_cycles", n, 20);
      chk("miss_hit", int'(hit), 0);
      chk("miss_score", int'(score), 1);

      // Round 3: wrong key, then correct key on the timeout cycle
      wait_show0();
      cyc(2);
      press((m_pos == 4'd9) ? 4'd1 : m_pos + 4'd1);
      cyc(SHOW_LEN - 4);
      press(m_pos);
      chk("late_hit", int'(hit), 1);
      chk("late_score", int'(score), 2);
      chk("late_pos_held", int'(position != 4'd0), 1);

      wait_over();
      chk("done_over", int'(game_over), 1);
      chk("done_ingame", int'(inGame), 0);
      chk("done_score", int'(score), 2);
      chk("done_position", int'(position), 0);

      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("restart_score", int'(score), 0);
      chk("restart_over", int'(game_over), 0);
      chk("restart_ingame", int'(inGame), 1);

      // Asynchronous reset mid-SHOW with score 1
      wait_show0();
      press(m_pos);
      chk("pre_rst_score", int'(score), 1);
      wait_show0();
      cyc(2);
      #2 rst = 1'b0;
      #1;
      chk("arst_ingame", int'(inGame), 0);
      chk("arst_position", int'(position), 0);
      chk("arst_hit", int'(hit), 0);
      chk("arst_score", int'(score), 0);
      chk("arst_over", int'(game_over), 0);
      #4 rst = 1'b1;
      #3;
      cyc(2);

      // Many games to exercise back-to-back spawn uniqueness
      g = 0;
      while (spawn_cnt < 1000 && g < 600) begin
         start = 1'b1;
         cyc(1);
         start = 1'b0;
         for (int r = 0; r < ROUNDS; r++) begin
            wait_show0();
            cyc(r);
            press(m_pos);
         end
         wait_over();
         g++;
      end
      chk("spawn_count_reached", int'(spawn_cnt >= 1000), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mole_game_ctrl.md
MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per game tick (1 ms at 50 MHz).
REQ-002 Parameter SHOW_TICKS, default 800, ticks a target stays lit awaiting a hit.
REQ-003 Parameter FEEDBACK_TICKS, default 200, ticks the hit/miss result is held on screen.
REQ-004 Parameter ROUNDS, default 20, targets per game.
REQ-005 clk  input  1  system clock, 50 MHz; the block SHALL use one clock only.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  synchronous level from the start button; its rising edge begins a game.
REQ-008 key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
REQ-009 key_code  input  4  pressed cell, 1..9; other values are never a hit.
REQ-010 inGame  output  1  high while a game runs; drives the display's inGame.
REQ-011 position  output  4  lit cell, 1..9; 0 means no cell lit.
REQ-012 hit  output  1  high while the current target has been hit.
REQ-013 score  output  8  hits this game, unsigned binary.
REQ-014 game_over  output  1  high from the end of the final round until the next game starts.

Function
REQ-015 States SHALL be IDLE, SPAWN, SHOW, FEEDBACK, DONE, all registered.
REQ-016 IDLE and DONE: inGame=0, position=0, hit=0; a start rising edge SHALL go to SPAWN and clear score, the round counter and game_over in that cycle.
REQ-017 A start rising edge in SPAWN, SHOW or FEEDBACK SHALL be ignored.
REQ-018 SPAWN SHALL last exactly one cycle, load position, clear hit, and go to SHOW; position is valid two cycles after the start edge.
REQ-019 Position source: an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5, stepping every cycle; candidate = (lfsr mod 9)+1.
REQ-020 If the candidate equals the previous position, the block SHALL use candidate+1, wrapping 9 to 1.
REQ-021 A tick prescaler SHALL restart on entry to SHOW and to FEEDBACK, so each state lasts exactly SHOW_TICKS*TICK_DIV or FEEDBACK_TICKS*TICK_DIV cycles.
REQ-022 SHOW: key_valid with key_code==position SHALL, on the next cycle, set hit=1, increment score, and enter FEEDBACK with position held.
REQ-023 SHOW: key_valid with any other key_code SHALL be ignored.
REQ-024 SHOW timeout with no hit SHALL enter FEEDBACK with hit=0 and position=0.
REQ-025 A correct key in the same cycle as the SHOW timeout SHALL count as a hit.
REQ-026 key_valid in IDLE, SPAWN, FEEDBACK or DONE SHALL be ignored.
REQ-027 FEEDBACK end SHALL increment the round counter, then enter DONE (game_over=1) if it equals ROUNDS, otherwise enter SPAWN.
REQ-028 score SHALL saturate at 255; score is held in DONE.

Reset
REQ-029 Reset SHALL force IDLE, position=0, hit=0, score=0, inGame=0, game_over=0, round counter=0, prescaler=0, LFSR=8'hA5, previous position=0, start-edge register=0.
REQ-030 Reset mid-game SHALL abort immediately, with no partial score retained.

Structure
REQ-031 A shared package SHALL hold the state encoding, the LFSR seed and the LFSR tap constants.
REQ-032 The prescaler SHALL be a sub-module, tick_gen (inputs clk, rst, clear; output one-cycle tick).

Verification (TICK_DIV=4, SHOW_TICKS=5, FEEDBACK_TICKS=2, ROUNDS=3)
REQ-033 Start edge at cycle 10 -> inGame=1 at cycle 11, position in 1..9 at cycle 12, score=0.
REQ-034 Correct key 3 cycles into SHOW -> hit=1 and score=1 next cycle; SPAWN exactly 8 cycles after FEEDBACK entry.
REQ-035 No key -> FEEDBACK exactly 20 cycles after SHOW entry with position=0, hit=0, score unchanged.
REQ-036 Wrong key_code, then correct key_code on the timeout cycle -> wrong key ignored, hit=1, score+1.
REQ-037 Three rounds with 2 hits -> DONE, game_over=1, inGame=0, score=2; new start edge -> score=0, game_over=0.
REQ-038 Assert rst mid-SHOW with score=1 -> all outputs reset asynchronously; 1000 spawns never repeat a position back-to-back.
